// File: rtl/fpu_half_pkg.sv
// Shared types, FP16 constants and the result flag decoder for the
// bit-serial fp16 adder sequencer.
package fpu_half_pkg;

    // Top-level operation sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Four strobe phases that make up one serial bit period
    typedef enum logic [1:0] {
        SETUP = 2'd0,
        BHI   = 2'd1,
        GAP   = 2'd2,
        AHI   = 2'd3
    } phase_t;

    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_QNAN    = 16'h7FFF;

    // Returns {nan, inf, zero} for an fp16 value; sign is ignored.
    function automatic logic [2:0] fp16_flags(input logic [15:0] y);
        logic exp_max;
        exp_max = (y[14:10] == FP16_EXP_MAX);
        return {exp_max && (y[9:0] != 10'd0),
                exp_max && (y[9:0] == 10'd0),
                (y[14:0] == 15'd0)};
    endfunction

endpackage

// File: rtl/fp_add_half_seq_if.sv
// Request/response channel between the issue logic and the fp16 add sequencer.
interface fp_add_half_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic [2:0]  rsp_flags;

    // Issue side: sends operands, consumes results
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_flags
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_flags
    );
endinterface

// File: rtl/fp16_serializer.sv
// Shifts two fp16 operands MSB-first into the serial adder using
// non-overlapping two-phase strobes: SETUP, sckb high, GAP, scka high.
module fp16_serializer
    import fpu_half_pkg::*;
#(
    parameter int PHASE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic        sdi_a,
    output logic        sdi_b,
    output logic        sckb,
    output logic        scka
);

    localparam int            CW       = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_CYC - 1);

    logic          active_reg;
    phase_t        phase_reg;
    logic [CW-1:0] cyc_reg;
    logic [3:0]    idx_reg;
    logic          sckb_reg;
    logic          scka_reg;
    logic          phase_end;
    logic          bit_end;
    logic          last_bit;

    assign phase_end = active_reg && (cyc_reg == CYC_LAST);
    assign bit_end   = phase_end && (phase_reg == AHI);
    assign last_bit  = (idx_reg == 4'd0);
    // High on the edge that ends the scka pulse of bit 0
    assign done      = bit_end && last_bit;

    // Phase and bit sequencing; the cycle counter never passes PHASE_CYC-1
    // and the bit index stops at 0 when the serializer goes inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= 1'b0;
            phase_reg  <= SETUP;
            cyc_reg    <= '0;
            idx_reg    <= 4'd0;
            sckb_reg   <= 1'b0;
            scka_reg   <= 1'b0;
        end else if (start) begin
            active_reg <= 1'b1;
            phase_reg  <= SETUP;
            cyc_reg    <= '0;
            idx_reg    <= 4'd15;
            sckb_reg   <= 1'b0;
            scka_reg   <= 1'b0;
        end else if (phase_end) begin
            cyc_reg <= '0;
            case (phase_reg)
                SETUP: begin
                    phase_reg <= BHI;
                    sckb_reg  <= 1'b1;
                end
                BHI: begin
                    phase_reg <= GAP;
                    sckb_reg  <= 1'b0;
                end
                GAP: begin
                    phase_reg <= AHI;
                    scka_reg  <= 1'b1;
                end
                default: begin
                    phase_reg <= SETUP;
                    scka_reg  <= 1'b0;
                    if (last_bit) begin
                        active_reg <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg - 4'd1;
                    end
                end
            endcase
        end else if (active_reg) begin
            cyc_reg <= cyc_reg + 1'b1;
        end
    end

    assign sckb = sckb_reg;
    assign scka = scka_reg;

    // Lane 0 carries operand A, lane 1 operand B. Bit 15 goes straight to
    // sdi on load; the remaining bits wait in a 15-bit shift register.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [15:0] opnd;
            logic [14:0] sh_reg;
            logic        sdi_reg;

            assign opnd = (gi == 0) ? a : b;

            // Load the operand, then advance one bit at the end of each AHI
            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_reg  <= '0;
                    sdi_reg <= 1'b0;
                end else if (start) begin
                    sh_reg  <= opnd[14:0];
                    sdi_reg <= opnd[15];
                end else if (bit_end) begin
                    sh_reg  <= {sh_reg[13:0], 1'b0};
                    sdi_reg <= last_bit ? 1'b0 : sh_reg[14];
                end
            end
        end
    endgenerate

    assign sdi_a = g_lane[0].sdi_reg;
    assign sdi_b = g_lane[1].sdi_reg;

endmodule

// File: rtl/fp_add_half_seq.sv
// Sequencer for the bit-serial fp16 adder: accepts one operand pair,
// serializes it into the adder, waits for the sum to settle, then holds
// the registered result and its flags until the consumer takes it.
module fp_add_half_seq
    import fpu_half_pkg::*;
#(
    parameter int PHASE_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_half_seq_if.slave    bus,
    output logic                sdi_a,
    output logic                sdi_b,
    output logic                sckb,
    output logic                scka,
    input  logic [15:0]         add_y
);

    localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_t        state_reg;
    logic [SW-1:0] settle_reg;
    logic          rsp_valid_reg;
    logic [15:0]   rsp_y_reg;
    logic [2:0]    rsp_flags_reg;
    logic          idle;
    logic          start;
    logic          ser_done;

    // Operands are only sampled while idle and out of reset
    assign idle          = (state_reg == IDLE) && !rst;
    assign start         = idle && bus.req_valid;
    assign bus.req_ready = idle;

    fp16_serializer #(
        .PHASE_CYC (PHASE_CYC)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (bus.req_a),
        .b     (bus.req_b),
        .done  (ser_done),
        .sdi_a (sdi_a),
        .sdi_b (sdi_b),
        .sckb  (sckb),
        .scka  (scka)
    );

    // Operation FSM: handshakes, settle timing and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            settle_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_y_reg     <= 16'h0000;
            rsp_flags_reg <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_done) begin
                        state_reg  <= SETTLE;
                        settle_reg <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        rsp_y_reg     <= add_y;
                        rsp_flags_reg <= fp16_flags(add_y);
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_y     = rsp_y_reg;
    assign bus.rsp_flags = rsp_flags_reg;

endmodule

// File: tb/tb_fp_add_half_seq.sv
// Bench for fp_add_half_seq with a behavioural serial fp16 adder attached.
module tb_fp_add_half_seq;
    import fpu_half_pkg::*;

    localparam int P     = 1;
    localparam int S     = 2;
    localparam int LAT   = 64 * P + S;
    localparam int TPUT  = 64 * P + S + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_add_half_seq_if bus();
    logic        sdi_a, sdi_b, sckb, scka;
    logic [15:0] add_y;

    fp_add_half_seq #(.PHASE_CYC(P), .SETTLE_CYC(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .sdi_a (sdi_a),
        .sdi_b (sdi_b),
        .sckb  (sckb),
        .scka  (scka),
        .add_y (add_y)
    );

    // Truncating fp16 add reference
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [14:0] mx, my, s;
        int ex, eyy, d;
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[14:10] == FP16_EXP_MAX) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == FP16_EXP_MAX) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == FP16_EXP_MAX) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == FP16_EXP_MAX) && (b[9:0] == 10'd0);
        if (a_nan || b_nan) return FP16_QNAN;
        if (a_inf && b_inf) return (a[15] == b[15]) ? a : FP16_QNAN;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        mx  = {1'b0, (x[14:10] != 5'd0), x[9:0], 3'b000};
        my  = {1'b0, (y[14:10] != 5'd0), y[9:0], 3'b000};
        ex  = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
        eyy = (y[14:10] == 5'd0) ? 1 : int'(y[14:10]);
        d   = ex - eyy;
        my  = (d > 14) ? 15'd0 : (my >> d);
        s   = (x[15] == y[15]) ? (mx + my) : (mx - my);
        if (s == 15'd0) return 16'h0000;
        if (s[14]) begin s = s >> 1; ex++; end
        for (int i = 0; i < 14; i++) begin
            if (!s[13] && ex > 1) begin s = s << 1; ex--; end
        end
        if (ex >= 31) return {x[15], 5'h1F, 10'h000};
        return {x[15], (s[13] ? 5'(ex) : 5'd0), s[12:3]};
    endfunction

    function automatic logic [2:0] exp_flags(input logic [15:0] y);
        if (y[14:0] == 15'h0) return 3'b001;
        if (y[14:10] != 5'h1F) return 3'b000;
        return (y[9:0] == 10'h0) ? 3'b010 : 3'b100;
    endfunction

    // Serial adder: sckb buffers the input bits, scka shifts them in MSB-first
    logic        ib_a = 1'b0, ib_b = 1'b0;
    logic [15:0] sr_a = 16'h0, sr_b = 16'h0;
    always @(posedge sckb) begin ib_a <= sdi_a; ib_b <= sdi_b; end
    always @(posedge scka) begin sr_a <= {sr_a[14:0], ib_a}; sr_b <= {sr_b[14:0], ib_b}; end
    assign add_y = ref_add(sr_a, sr_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: cumulative pulse counts and rule violations
    int nb_cnt = 0, na_cnt = 0, viol_cnt = 0;
    logic prev_sckb = 1'b0, prev_scka = 1'b0;
    logic [1:0] prev_sdi = 2'b00, sdi_at_b = 2'b00;
    always @(negedge clk) begin
        if (sckb && !prev_sckb) begin
            nb_cnt++;
            sdi_at_b = {sdi_a, sdi_b};
            if ({sdi_a, sdi_b} != prev_sdi) viol_cnt++;
        end
        if (sckb && prev_sckb && ({sdi_a, sdi_b} != sdi_at_b)) viol_cnt++;
        if (!sckb && prev_sckb && ({sdi_a, sdi_b} != sdi_at_b)) viol_cnt++;
        if (scka && !prev_scka) na_cnt++;
        if (sckb && scka) viol_cnt++;
        if ((sckb && prev_scka) || (scka && prev_sckb)) viol_cnt++;
        prev_sckb = sckb;
        prev_scka = scka;
        prev_sdi  = {sdi_a, sdi_b};
    end

    typedef struct packed {
        logic [15:0] y;
        logic [2:0]  f;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int acc_cyc = 0, nb0 = 0, na0 = 0, v0 = 0;

    // Drive a request from a negedge and return one negedge after acceptance
    task automatic send_req(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ey, input logic [2:0] ef);
        int w = 0;
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        while (!bus.req_ready && w < 1000) begin @(negedge clk); w++; end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
        end
        exp_q.push_back('{y: ey, f: ef});
        @(negedge clk);
        acc_cyc = cyc;
        nb0 = nb_cnt; na0 = na_cnt; v0 = viol_cnt;
        bus.req_valid = 1'b0;
        bus.req_a = 16'h0;
        bus.req_b = 16'h0;
    endtask

    task automatic wait_rsp(output int lat);
        int w = 0;
        while (!bus.rsp_valid && w < 1000) begin @(negedge clk); w++; end
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", bus.rsp_valid);
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
        checks++;
        if ({bus.rsp_y, bus.rsp_flags} !== 19'h0) begin
            errors++; $display("FAIL reset_rsp_data: got y=%h flags=%b required 0", bus.rsp_y, bus.rsp_flags);
        end
        checks++;
        if ({sdi_a, sdi_b, sckb, scka} !== 4'b0000) begin
            errors++; $display("FAIL reset_serial: got %b required 0000", {sdi_a, sdi_b, sckb, scka});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b required 1", bus.req_ready); end
        $display("reset done");
    endtask

    task automatic test_basic();
        logic [15:0] ta [3] = '{16'h3C00, 16'h3C00, 16'h7C00};
        logic [15:0] tb [3] = '{16'h3C00, 16'hBC00, 16'hFC00};
        logic [15:0] ty [3] = '{16'h4000, 16'h0000, 16'h7FFF};
        logic [2:0]  tf [3] = '{3'b000, 3'b001, 3'b100};
        int lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send_req(ta[i], tb[i], ty[i], tf[i]);
            wait_rsp(lat);
            e = exp_q.pop_front();
            checks++;
            if (bus.rsp_y !== e.y) begin errors++; $display("FAIL basic_y[%0d]: got %h required %h", i, bus.rsp_y, e.y); end
            checks++;
            if (bus.rsp_flags !== e.f) begin errors++; $display("FAIL basic_flags[%0d]: got %b required %b", i, bus.rsp_flags, e.f); end
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL basic_latency[%0d]: got %0d required %0d", i, lat, LAT); end
            checks++;
            if ((nb_cnt - nb0) != 16 || (na_cnt - na0) != 16 || (viol_cnt - v0) != 0) begin
                errors++;
                $display("FAIL basic_strobes[%0d]: got sckb=%0d scka=%0d viol=%0d required 16 16 0",
                         i, nb_cnt - nb0, na_cnt - na0, viol_cnt - v0);
            end
            $display("basic %04h + %04h -> y=%04h flags=%03b lat=%0d", ta[i], tb[i], bus.rsp_y, bus.rsp_flags, lat);
            release_rsp();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++; $display("FAIL basic_release[%0d]: got valid=%b ready=%b required 0 1", i, bus.rsp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        send_req(16'h3C00, 16'h3C00, 16'h4000, 3'b000);
        wait_rsp(lat);
        e = exp_q.pop_front();
        bus.req_valid = 1'b1;
        bus.req_a = 16'h1234;
        bus.req_b = 16'h5678;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.rsp_y !== e.y || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got y=%h valid=%b ready=%b required y=%h valid=1 ready=0",
                         k, bus.rsp_y, bus.rsp_valid, bus.req_ready, e.y);
            end
            @(negedge clk);
        end
        $display("bp held %04h for 10 cycles", bus.rsp_y);
        bus.rsp_ready = 1'b1;
        bus.req_a = 16'h4000;
        bus.req_b = 16'h3C00;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
        end
        send_req(16'h4000, 16'h3C00, 16'h4200, 3'b000);
        wait_rsp(lat);
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_y !== e.y || bus.rsp_flags !== e.f) begin
            errors++; $display("FAIL bp_second: got y=%h flags=%b required %h %b", bus.rsp_y, bus.rsp_flags, e.y, e.f);
        end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL bp_latency: got %0d required %0d", lat, LAT); end
        $display("bp second 4000 + 3c00 -> y=%04h flags=%03b lat=%0d", bus.rsp_y, bus.rsp_flags, lat);
        release_rsp();
    endtask

    task automatic test_rst_mid_shift();
        int lat, w;
        exp_t e;
        send_req(16'h3C00, 16'h3C00, 16'h4000, 3'b000);
        w = 0;
        while ((cyc - acc_cyc) < 30 && w < 100) begin @(negedge clk); w++; end
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || (cyc - acc_cyc) != 30) begin
            errors++; $display("FAIL rst_busy: got ready=%b valid=%b at cycle %0d required 0 0 30",
                                bus.req_ready, bus.rsp_valid, cyc - acc_cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.rsp_flags, sdi_a, sdi_b, sckb, scka} !== 25'h0) begin
            errors++;
            $display("FAIL rst_outputs: got ready=%b valid=%b y=%h flags=%b serial=%b required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.rsp_flags, {sdi_a, sdi_b, sckb, scka});
        end
        rst = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: got ready=%b required 1", bus.req_ready); end
        send_req(16'h4000, 16'h3C00, 16'h4200, 3'b000);
        wait_rsp(lat);
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_y !== e.y || bus.rsp_flags !== e.f) begin
            errors++; $display("FAIL rst_next_op: got y=%h flags=%b required %h %b", bus.rsp_y, bus.rsp_flags, e.y, e.f);
        end
        checks++;
        if ((nb_cnt - nb0) != 16 || (na_cnt - na0) != 16 || lat !== LAT) begin
            errors++; $display("FAIL rst_next_timing: got sckb=%0d scka=%0d lat=%0d required 16 16 %0d",
                                nb_cnt - nb0, na_cnt - na0, lat, LAT);
        end
        $display("after rst 4000 + 3c00 -> y=%04h flags=%03b lat=%0d", bus.rsp_y, bus.rsp_flags, lat);
        release_rsp();
    endtask

    task automatic test_random();
        logic [15:0] a, b, ey;
        int lat, prev_acc;
        exp_t e;
        prev_acc = 0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            a  = {1'($urandom_range(1, 0)), 5'($urandom_range(30, 1)), 10'($urandom_range(1023, 0))};
            b  = {1'($urandom_range(1, 0)), 5'($urandom_range(30, 1)), 10'($urandom_range(1023, 0))};
            ey = ref_add(a, b);
            send_req(a, b, ey, exp_flags(ey));
            if (n > 0) begin
                checks++;
                if ((acc_cyc - prev_acc) != TPUT) begin
                    errors++; $display("FAIL rand_tput[%0d]: got %0d required %0d", n, acc_cyc - prev_acc, TPUT);
                end
            end
            prev_acc = acc_cyc;
            wait_rsp(lat);
            e = exp_q.pop_front();
            checks++;
            if (bus.rsp_y !== e.y || bus.rsp_flags !== e.f) begin
                errors++; $display("FAIL rand_result[%0d]: %h+%h got y=%h flags=%b required %h %b",
                                    n, a, b, bus.rsp_y, bus.rsp_flags, e.y, e.f);
            end
            checks++;
            if ((nb_cnt - nb0) != 16 || (na_cnt - na0) != 16 || (viol_cnt - v0) != 0 || lat !== LAT) begin
                errors++;
                $display("FAIL rand_strobes[%0d]: got sckb=%0d scka=%0d viol=%0d lat=%0d required 16 16 0 %0d",
                         n, nb_cnt - nb0, na_cnt - na0, viol_cnt - v0, lat, LAT);
            end
            $display("rand %0d: %04h + %04h -> y=%04h flags=%03b", n, a, b, bus.rsp_y, bus.rsp_flags);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_rst_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
